apb_initiator: RTL and testbench

//  APB requester: turns a valid/ready command stream into APB3 SETUP/ACCESS transfers.

---
 rtl/apb_initiator.sv | 134 +++++++++++++
 tb/tb_apb_initiator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// apb_initiator: turns a valid/ready command stream into APB3 SETUP/ACCESS transfers, one at a time
// Ports: clk_cpu/nreset (sync, active-low); cmd_* command stream in (cmd_ready = IDLE & nreset);
//        rsp_* response stream out (rdata 0 for writes/aborts, error = PSLVERR or timeout);
//        apb_P* APB3 requester signals, all registered.
// Optional: APB_INITIATOR_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait cycles.
module apb_initiator #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_cpu,
  input  logic                  nreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] apb_PADDR,
  output logic                  apb_PSEL,
  output logic                  apb_PENABLE,
  output logic                  apb_PWRITE,
  output logic [31:0]           apb_PWDATA,
  input  logic                  apb_PREADY,
  input  logic [31:0]           apb_PRDATA,
  input  logic                  apb_PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [31:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif
  assign cmd_ready = (state_q == IDLE) & nreset;
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
`ifdef APB_INITIATOR_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        paddr_d  = cmd_addr;
        pwrite_d = cmd_write;
        pwdata_d = cmd_wdata;
        psel_d   = 1'b1;
        state_d  = SETUP;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_INITIATOR_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: if (apb_PREADY) begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = pwrite_q ? 32'h0 : apb_PRDATA;
        rsp_error_d = apb_PSLVERR;
        state_d     = RESP;
      end
`ifdef APB_INITIATOR_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        rsp_error_d = 1'b1;
        state_d     = RESP;
      end else cnt_d = cnt_q + CW'(1);
`endif
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_cpu) begin
    if (!nreset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
`ifdef APB_INITIATOR_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
`ifdef APB_INITIATOR_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  assign apb_PADDR   = paddr_q;
  assign apb_PSEL    = psel_q;
  assign apb_PENABLE = penable_q;
  assign apb_PWRITE  = pwrite_q;
  assign apb_PWDATA  = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;
endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator: directed + randomized checks of apb_initiator against a transaction-level model
module tb_apb_initiator;
  localparam int AW = 12;
  localparam int TO = 16;
`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk_cpu = 1'b0;
  logic nreset = 1'b0, cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = 32'h0, apb_PRDATA = 32'h0;
  logic apb_PREADY = 1'b0, apb_PSLVERR = 1'b0;
  logic cmd_ready, rsp_valid, rsp_error, apb_PSEL, apb_PENABLE, apb_PWRITE;
  logic [31:0] rsp_rdata, apb_PWDATA;
  logic [AW-1:0] apb_PADDR;
  int n_vec = 0, n_err = 0;
  // model: one command in flight on the bus, or one response waiting
  bit m_busy = 0, m_access = 0, m_rsp = 0, m_write = 0, m_err = 0;
  int m_waits = 0;
  logic [AW-1:0] m_addr = '0;
  logic [31:0] m_wdata = 32'h0, m_rdata = 32'h0;
  apb_initiator #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_cpu(clk_cpu), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
    .apb_PWRITE(apb_PWRITE), .apb_PWDATA(apb_PWDATA), .apb_PREADY(apb_PREADY),
    .apb_PRDATA(apb_PRDATA), .apb_PSLVERR(apb_PSLVERR)
  );
  always #5 clk_cpu = ~clk_cpu;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic void model_edge();
    if (!nreset) begin
      m_busy = 0; m_access = 0; m_rsp = 0; m_write = 0; m_err = 0;
      m_addr = '0; m_wdata = 32'h0; m_rdata = 32'h0;
    end else if (m_rsp) begin
      if (rsp_ready) m_rsp = 0;
    end else if (m_busy) begin
      if (!m_access) begin
        m_access = 1; m_waits = 0;
      end else if (apb_PREADY) begin
        m_busy = 0; m_access = 0; m_rsp = 1;
        m_rdata = m_write ? 32'h0 : apb_PRDATA; m_err = apb_PSLVERR;
      end else begin
        m_waits++;
        if (TO_EN && m_waits == TO) begin
          m_busy = 0; m_access = 0; m_rsp = 1; m_rdata = 32'h0; m_err = 1;
        end
      end
    end else if (cmd_valid) begin
      m_busy = 1; m_access = 0;
      m_addr = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata;
    end
  endfunction
  function automatic void compare();
    check("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !m_rsp && nreset));
    check("psel", 32'(apb_PSEL), 32'(m_busy));
    check("penable", 32'(apb_PENABLE), 32'(m_busy && m_access));
    check("paddr", 32'(apb_PADDR), 32'(m_addr));
    check("pwrite", 32'(apb_PWRITE), 32'(m_write));
    check("pwdata", apb_PWDATA, m_wdata);
    check("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    if (m_rsp) begin
      check("rsp_rdata", rsp_rdata, m_rdata);
      check("rsp_error", 32'(rsp_error), 32'(m_err));
    end
  endfunction
  task automatic tick();
    @(posedge clk_cpu);
    model_edge();
    @(negedge clk_cpu);
    compare();
  endtask
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("consumed_valid", 32'(rsp_valid), 32'h0);
    check("consumed_ready", 32'(cmd_ready), 32'h1);
  endtask
  initial begin
    @(negedge clk_cpu);
    tick();
    tick();
    check("rst_psel", 32'(apb_PSEL), 32'h0);
    check("rst_paddr", 32'(apb_PADDR), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    nreset = 1'b1;
    // 1: zero-wait write
    apb_PREADY = 1'b1;
    issue(1'b1, 12'h000, 32'h5);
    check("t1_setup_psel", 32'(apb_PSEL), 32'h1);
    check("t1_setup_penable", 32'(apb_PENABLE), 32'h0);
    check("t1_pwdata", apb_PWDATA, 32'h5);
    tick();
    check("t1_access_penable", 32'(apb_PENABLE), 32'h1);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t1_rsp_error", 32'(rsp_error), 32'h0);
    check("t1_psel_off", 32'(apb_PSEL), 32'h0);
    consume();
    // 2: read, response held 5 cycles with a competing command
    apb_PRDATA = 32'h055D4A80;
    issue(1'b0, 12'h008, 32'hFFFF_FFFF);
    tick();
    tick();
    apb_PRDATA = 32'h0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_rdata", rsp_rdata, 32'h055D4A80);
      check("t2_valid", 32'(rsp_valid), 32'h1);
      check("t2_cmd_ready", 32'(cmd_ready), 32'h0);
    end
    cmd_valid = 1'b0;
    consume();
    // 3: read with three wait states
    apb_PREADY = 1'b0;
    apb_PRDATA = 32'hCAFE_0003;
    issue(1'b0, 12'h3A4, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_psel", 32'(apb_PSEL), 32'h1);
      check("t3_penable", 32'(apb_PENABLE), 32'h1);
      check("t3_paddr", 32'(apb_PADDR), 32'h3A4);
      check("t3_no_rsp", 32'(rsp_valid), 32'h0);
    end
    apb_PREADY = 1'b1;
    tick();
    check("t3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("t3_rdata", rsp_rdata, 32'hCAFE_0003);
    consume();
    // 4: write with PSLVERR
    apb_PSLVERR = 1'b1;
    apb_PRDATA = 32'h1234_5678;
    issue(1'b1, 12'hFFC, 32'hA5A5_A5A5);
    tick();
    tick();
    check("t4_error", 32'(rsp_error), 32'h1);
    check("t4_rdata", rsp_rdata, 32'h0);
    apb_PSLVERR = 1'b0;
    consume();
    // 5: reset in ACCESS
    apb_PREADY = 1'b0;
    issue(1'b0, 12'h123, 32'h0);
    tick();
    nreset = 1'b0;
    tick();
    check("t5_psel", 32'(apb_PSEL), 32'h0);
    check("t5_penable", 32'(apb_PENABLE), 32'h0);
    check("t5_paddr", 32'(apb_PADDR), 32'h0);
    nreset = 1'b1;
    #1;
    check("t5_cmd_ready", 32'(cmd_ready), 32'h1);
    tick();
    check("t5_no_stale_rsp", 32'(rsp_valid), 32'h0);
    // 6: PREADY stuck low
    apb_PRDATA = 32'hDEAD_BEEF;
    issue(1'b0, 12'h040, 32'h0);
    tick();
`ifdef APB_INITIATOR_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      tick();
      check("t6_waiting", 32'(apb_PSEL), 32'h1);
    end
    tick();
    check("t6_abort_valid", 32'(rsp_valid), 32'h1);
    check("t6_abort_error", 32'(rsp_error), 32'h1);
    check("t6_abort_rdata", rsp_rdata, 32'h0);
    check("t6_abort_psel", 32'(apb_PSEL), 32'h0);
`else
    for (int i = 0; i < 100; i++) tick();
    check("t6_still_psel", 32'(apb_PSEL), 32'h1);
    check("t6_still_penable", 32'(apb_PENABLE), 32'h1);
    check("t6_no_rsp", 32'(rsp_valid), 32'h0);
    apb_PREADY = 1'b1;
    tick();
    check("t6_late_rdata", rsp_rdata, 32'hDEAD_BEEF);
`endif
    consume();
    // randomized traffic
    begin
      bit slow = 0;
      for (int i = 0; i < 4000; i++) begin
        if (i % 500 == 0) slow = 1'($urandom_range(0, 1));
        nreset      = ($urandom_range(0, 199) != 0);
        cmd_valid   = 1'($urandom_range(0, 1));
        cmd_write   = 1'($urandom_range(0, 1));
        cmd_addr    = AW'($urandom);
        cmd_wdata   = $urandom;
        rsp_ready   = 1'($urandom_range(0, 1));
        apb_PREADY  = slow ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
        apb_PRDATA  = $urandom;
        apb_PSLVERR = ($urandom_range(0, 4) == 0);
        tick();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
